r16_group_reorder: RTL and testbench
====================================

# r16_group_reorder

Receive-side output stage for the radix-16 pipeline. It consumes the data/valid stream driven by the last pipeline register stage and collects each group of 16 consecutive valid samples into one bank of a 2×16 ping-pong buffer. Each completed group is returned in 4-bit bit-reversed index order over a ready/valid handshake toward the output interface or memory writer. Overflow is detected and flagged; nothing upstream is ever stalled, because the pipeline has no backpressure.

## Interface
- P_WIDTH, 64, sample width in bits.
- P_ZERO, 64'h0, value driven on B0_out whenever Bc_out is low; also the reset value of the stored data.
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, synchronous and active-high; one clock; reset is synchronous active-high.
- A0_in  input  P_WIDTH  sample from the upstream pipeline register.
- Ac_in  input  1  sample valid; one sample per cycle while high.
- B0_out  output  P_WIDTH  reordered sample.
- Bc_out  output  1  output valid.
- Br_in  input  1  downstream ready; transfer when Bc_out & Br_in.
- ovf_out  output  1  sticky overflow flag.

## Operation
- State:
  - banks mem[0..1][0..15] of P_WIDTH flops;
  - full[1:0];
  - wr_bank and 4-bit wr_idx;
  - rd_bank and 4-bit rd_idx;
  - ovf.
- Write: when Ac_in=1 and full[wr_bank]=0 at the start of the cycle:
  - mem[wr_bank][wr_idx] <= A0_in and wr_idx increments.
  - When wr_idx=15 is written: full[wr_bank] <= 1, wr_bank toggles, wr_idx wraps to 0.
- Drop: Ac_in=1 while full[wr_bank]=1 (both banks hold unread groups). The sample is discarded, wr_idx is unchanged, and ovf <= 1. ovf clears only on rst.
- Read:
  - Bc_out = full[rd_bank].
  - B0_out = mem[rd_bank][rev(rd_idx)] when Bc_out=1, else P_ZERO.
  - rev(i) = {i[0],i[1],i[2],i[3]}.
- Transfer: on Bc_out & Br_in, rd_idx increments. When rd_idx=15 transfers: full[rd_bank] <= 0, rd_bank toggles, rd_idx wraps to 0.
- Same-cycle events:
  - A bank freed by the final read is not writable until the next cycle. A write that meets a full wr_bank in that cycle is dropped.
  - A write completing a group and a read starting on the same bank never collide: the read only sees the full flag from the next cycle.
- Bc_out, once high, stays high with B0_out stable until the transfer (AXI-style; no retraction).

## Timing
- Reset values:
  - Bc_out=0, B0_out=P_ZERO, ovf_out=0.
  - full=0, wr_bank=rd_bank=0, wr_idx=rd_idx=0, mem cleared to P_ZERO.
- rst is sampled on posedge and overrides all activity. Reset mid-group discards partial and complete groups, and no output is produced for them.
- Latency: the 16th sample of a group written at edge N gives Bc_out=1 from edge N to N+1, carrying element rev(0)=0.
- Throughput: with Br_in held at 1, one sample is output per cycle. Back-to-back groups stream with no bubble between the last element of bank k and the first element of bank k^1.
- Capacity: 32 samples buffered. The 33rd valid sample with no transfers is the first dropped.
- ovf_out rises at the edge that samples the dropped Ac_in.

## Configuration
- R16_REORDER_BITREV_EN:
  - Defined: read index is rev(rd_idx), as above.
  - Undefined: read index is rd_idx (natural order). The block becomes a plain 2×16 ping-pong group buffer, with identical handshake, latency and overflow behaviour.

## Test plan
- Bit-reverse order: Ac_in=1 for 16 cycles with A0_in=0..15, Br_in=1 -> B0_out sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 on consecutive cycles, then Bc_out=0.
- Back-to-back groups: 32 consecutive samples 0..31, Br_in=1 -> 32 outputs with no Bc_out gap. The second group is 16,24,20,…,31.
- Backpressure: one group, Br_in toggling 1,0,1,0 -> every element appears exactly once in bit-reverse order, and B0_out is stable while Bc_out=1 and Br_in=0.
- Overflow: 33 samples with Br_in=0 -> ovf_out=1 after the 33rd sample. Releasing Br_in then yields exactly 32 outputs (samples 0..31 reordered) and ovf_out stays 1.
- Reset mid-operation: 20 samples, then rst=1 for one cycle, then 16 samples 100..115 -> Bc_out=0 during and after reset until the new group completes. Only the reordered 100..115 are output, and ovf_out=0.
- Macro undefined: the same stimulus as the first scenario -> outputs 0..15 in natural order.

Source files
------------

// File: rtl/r16_group_reorder.sv
// r16_group_reorder
//   Output stage for the radix-16 pipeline. Collects each group of 16
//   consecutive valid samples into one bank of a 2x16 ping-pong buffer.
//   Each completed group is returned over a ready/valid handshake.
//   The upstream pipeline cannot be stalled. A sample that arrives while both
//   banks hold unread groups is dropped, and a sticky overflow flag is set.
//
//   Configuration macro: R16_REORDER_BITREV_EN
//     defined   : a group is read out in 4-bit bit-reversed index order
//     undefined : a group is read out in natural order (plain ping-pong buffer)
//
// Ports
//   clk     : clock
//   rst     : synchronous active-high reset
//   A0_in   : upstream sample
//   Ac_in   : upstream sample valid
//   B0_out  : output sample (P_ZERO while Bc_out is low)
//   Bc_out  : output valid
//   Br_in   : downstream ready
//   ovf_out : sticky overflow flag
module r16_group_reorder #(
  parameter int unsigned        P_WIDTH = 64,
  parameter logic [P_WIDTH-1:0] P_ZERO  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [P_WIDTH-1:0] A0_in,
  input  logic               Ac_in,
  output logic [P_WIDTH-1:0] B0_out,
  output logic               Bc_out,
  input  logic               Br_in,
  output logic               ovf_out
);

  logic [P_WIDTH-1:0] mem_q [2][16];
  logic [1:0]         full_q, full_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [3:0]         wr_idx_q, wr_idx_d;
  logic [3:0]         rd_idx_q, rd_idx_d;
  logic               ovf_q, ovf_d;
  logic [3:0]         rd_addr;
  logic               wr_en, drop, xfer;

  // Writability is judged on the registered full flags. A bank freed by this
  // cycle's final read therefore only becomes writable on the next cycle.
  assign wr_en = Ac_in & ~full_q[wr_bank_q];
  assign drop  = Ac_in &  full_q[wr_bank_q];
  assign xfer  = full_q[rd_bank_q] & Br_in;

`ifdef R16_REORDER_BITREV_EN
  assign rd_addr = {rd_idx_q[0], rd_idx_q[1], rd_idx_q[2], rd_idx_q[3]};
`else
  assign rd_addr = rd_idx_q;
`endif

  assign Bc_out  = full_q[rd_bank_q];
  assign B0_out  = Bc_out ? mem_q[rd_bank_q][rd_addr] : P_ZERO;
  assign ovf_out = ovf_q;

  // A write can only complete into a bank that was not full. A read can only
  // free a bank that was full. The two updates to full_d never touch the same
  // bit in the same cycle.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    ovf_d     = ovf_q | drop;
    if (xfer) begin
      rd_idx_d = rd_idx_q + 4'd1;
      if (rd_idx_q == 4'hF) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
    if (wr_en) begin
      wr_idx_d = wr_idx_q + 4'd1;
      if (wr_idx_q == 4'hF) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      ovf_q     <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 16; i++)
          mem_q[b][i] <= P_ZERO;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      ovf_q     <= ovf_d;
      if (wr_en) mem_q[wr_bank_q][wr_idx_q] <= A0_in;
    end
  end

endmodule

// File: tb/tb_r16_group_reorder.sv
module tb_r16_group_reorder;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] A0_in = '0;
  logic         Ac_in = 1'b0;
  logic [W-1:0] B0_out;
  logic         Bc_out;
  logic         Br_in = 1'b0;
  logic         ovf_out;

  r16_group_reorder #(.P_WIDTH(W), .P_ZERO('0)) dut (
    .clk(clk), .rst(rst), .A0_in(A0_in), .Ac_in(Ac_in),
    .B0_out(B0_out), .Bc_out(Bc_out), .Br_in(Br_in), .ovf_out(ovf_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Position within a group of the k-th element read out.
  function automatic int perm(input int k);
`ifdef R16_REORDER_BITREV_EN
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
`else
    return k;
`endif
  endfunction

  // Reference model: completed groups held as a flat queue (16 entries per
  // group), a partial group being gathered, and a read position in the head group.
  logic [W-1:0] stored[$];
  logic [W-1:0] part[$];
  int           m_rd  = 0;
  logic         m_ovf = 1'b0;
  bit           chk_en = 1'b0;
  int           cyc_n = 0;

  always @(posedge clk) begin
    int  ngrp;
    bit  do_x, do_w;
    cyc_n++;
    if (rst) begin
      stored.delete(); part.delete(); m_rd = 0; m_ovf = 1'b0;
    end else begin
      ngrp = stored.size() / 16;
      do_x = (ngrp > 0) && Br_in;
      do_w = Ac_in && (ngrp < 2);
      if (Ac_in && ngrp == 2) m_ovf = 1'b1;
      if (do_x) begin
        m_rd++;
        if (m_rd == 16) begin
          repeat (16) void'(stored.pop_front());
          m_rd = 0;
        end
      end
      if (do_w) begin
        part.push_back(A0_in);
        if (part.size() == 16) begin
          foreach (part[i]) stored.push_back(part[i]);
          part.delete();
        end
      end
    end
  end

  // Per-cycle comparison plus a log of accepted outputs.
  logic [W-1:0] out_log[$];
  int           out_cyc[$];

  always @(negedge clk) begin
    logic         e_bc;
    logic [W-1:0] e_b0;
    if (chk_en) begin
      e_bc = (stored.size() >= 16);
      e_b0 = e_bc ? stored[perm(m_rd)] : '0;
      chk("Bc_out", {63'd0, Bc_out}, {63'd0, e_bc});
      chk("B0_out", B0_out, e_b0);
      chk("ovf_out", {63'd0, ovf_out}, {63'd0, m_ovf});
      if (Bc_out && Br_in) begin
        out_log.push_back(B0_out);
        out_cyc.push_back(cyc_n);
      end
    end
  end

  task automatic step(input logic ac, input logic [W-1:0] d, input logic br);
    Ac_in = ac; A0_in = d; Br_in = br;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    out_log.delete(); out_cyc.delete();
  endtask

  int exp1[16];

  initial begin
`ifdef R16_REORDER_BITREV_EN
    exp1 = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
    exp1 = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
    @(posedge clk); #1;
    do_reset();
    chk("reset Bc", {63'd0, Bc_out}, '0);
    chk("reset B0", B0_out, '0);
    chk("reset ovf", {63'd0, ovf_out}, '0);

    // One group, always ready
    for (int i = 0; i < 16; i++) step(1'b1, W'(i), 1'b1);
    chk("grp1 first Bc", {63'd0, Bc_out}, 64'd1);
    chk("grp1 first B0", B0_out, 64'd0);
    repeat (20) step(1'b0, '0, 1'b1);
    chk("grp1 count", W'(out_log.size()), 64'd16);
    for (int i = 0; i < 16; i++) chk("grp1 order", out_log[i], W'(exp1[i]));
    chk("grp1 idle Bc", {63'd0, Bc_out}, '0);

    // Two back-to-back groups
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, W'(i), 1'b1);
    repeat (20) step(1'b0, '0, 1'b1);
    chk("b2b count", W'(out_log.size()), 64'd32);
    for (int i = 0; i < 32; i++) chk("b2b order", out_log[i], W'(16 * (i / 16) + exp1[i % 16]));
    chk("b2b no gap", W'(out_cyc[31] - out_cyc[0]), 64'd31);

    // Ready toggling
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, W'(i + 50), W'(i % 2 == 0));
    for (int i = 0; i < 40; i++) step(1'b0, '0, W'(i % 2 == 0));
    chk("bp count", W'(out_log.size()), 64'd16);
    for (int i = 0; i < 16; i++) chk("bp order", out_log[i], W'(50 + exp1[i]));

    // Overflow: 33 samples, no ready
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, W'(i), 1'b0);
    chk("ovf before 33rd", {63'd0, ovf_out}, '0);
    step(1'b1, W'(32), 1'b0);
    chk("ovf after 33rd", {63'd0, ovf_out}, 64'd1);
    repeat (40) step(1'b0, '0, 1'b1);
    chk("ovf count", W'(out_log.size()), 64'd32);
    for (int i = 0; i < 32; i++) chk("ovf order", out_log[i], W'(16 * (i / 16) + exp1[i % 16]));
    chk("ovf sticky", {63'd0, ovf_out}, 64'd1);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, W'(i), 1'b0);
    do_reset();
    chk("rst mid Bc", {63'd0, Bc_out}, '0);
    for (int i = 0; i < 16; i++) step(1'b1, W'(100 + i), 1'b1);
    repeat (20) step(1'b0, '0, 1'b1);
    chk("rst mid count", W'(out_log.size()), 64'd16);
    for (int i = 0; i < 16; i++) chk("rst mid order", out_log[i], W'(100 + exp1[i]));
    chk("rst mid ovf", {63'd0, ovf_out}, '0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(1'b1 & ($urandom_range(0, 9) < 7), {$urandom, $urandom},
             1'b1 & ($urandom_range(0, 9) < (i % 400 < 200 ? 3 : 8)));
      end
    end
    repeat (40) step(1'b0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
